ula_seq: RTL and testbench

Command sequencer that sits in front of the 4-bit `ula` ALU. It accepts one operation at a time over a valid/ready command port and drives the ALU operand and select lines from registers. After a fixed settle cycle it captures the ALU result and returns it over a valid/ready response port. It also keeps a 4-bit accumulator that can feed operand A, and counts completed operations. The ALU stays combinational and external; `ula_seq` is the initiator side of the ALU interface.

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_sel_enc.sv | 16 +
 rtl/ula_seq.sv | 148 ++++++++++++++
 tb/tb_ula_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ula ALU initiators.
// Data width, opcode values and sequencer state encoding.
package ula_pkg;

  localparam int DW = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/ula_sel_enc.sv
// Opcode to replicated ula select buses.
// Each select bus carries one opcode bit on all three lines.
module ula_sel_enc
  import ula_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [2:0] x_o,
  output logic [2:0] y_o,
  output logic [2:0] z_o
);

  assign x_o = {3{op_i[0]}};
  assign y_o = {3{op_i[1]}};
  assign z_o = {3{op_i[2]}};

endmodule

// File: rtl/ula_seq.sv
// Command sequencer driving an external combinational ula.
// IDLE accepts, EXEC lets the ALU settle, RESP returns the result.
module ula_seq
  import ula_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DW-1:0]    cmd_a,
  input  logic [DW-1:0]    cmd_b,
  input  logic             cmd_use_acc,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [2:0]       alu_x,
  output logic [2:0]       alu_y,
  output logic [2:0]       alu_z,
  input  logic [DW-1:0]    alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic [DW-1:0]    acc,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       x_q, x_d;
  logic [2:0]       y_q, y_d;
  logic [2:0]       z_q, z_d;
  logic [DW-1:0]    data_q, data_d;
  logic             zero_q, zero_d;
  logic [2:0]       rop_q, rop_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] enc_x, enc_y, enc_z;

  ula_sel_enc u_enc (
    .op_i (cmd_op),
    .x_o  (enc_x),
    .y_o  (enc_y),
    .z_o  (enc_z)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    data_d  = data_q;
    zero_d  = zero_q;
    rop_d   = rop_q;
    acc_d   = acc_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // acc here is the previous result
          a_d     = cmd_use_acc ? acc_q : cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          x_d     = enc_x;
          y_d     = enc_y;
          z_d     = enc_z;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = alu_s;
        acc_d   = alu_s;
        zero_d  = (alu_s == '0);
        rop_d   = op_q;
        vld_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      rop_q   <= '0;
      acc_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      rop_q   <= rop_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready = rst_n & (state_q == ST_IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_z     = z_q;
  assign rsp_valid = vld_q;
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_op    = rop_q;
  assign acc       = acc_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq with a behavioural ula.
// Counter width 2 so the wrap is reached quickly.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_x, alu_y, alu_z;
  logic [3:0] alu_s;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_zero;
  logic [2:0] rsp_op;
  logic [3:0] acc;
  logic [1:0] op_count;

  always #5 clk = ~clk;

  ula_seq #(.CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_z       (alu_z),
    .alu_s       (alu_s),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_zero    (rsp_zero),
    .rsp_op      (rsp_op),
    .acc         (acc),
    .op_count    (op_count)
  );

  // external ALU stand-in, decoding one line of each select bus
  logic [2:0] ula_sel;
  assign ula_sel = {alu_z[2], alu_y[1], alu_x[0]};
  always_comb begin
    alu_s = 4'h0;
    case (ula_sel)
      3'd0: alu_s = alu_a + alu_b;
      3'd1: alu_s = alu_a - alu_b;
      3'd2: alu_s = alu_a << alu_b;
      3'd3: alu_s = alu_a >> alu_b;
      3'd4: alu_s = alu_a & alu_b;
      3'd5: alu_s = alu_a | alu_b;
      3'd6: alu_s = alu_a ^ alu_b;
      default: alu_s = ~alu_a;
    endcase
  end

  typedef struct {
    logic [3:0] d;
    logic [2:0] op;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] m_acc = 4'h0;
  logic [1:0] m_cnt = 2'd0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_res(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b);
    logic [4:0] sum;
    case (op)
      3'd0: begin sum = a + b; return sum[3:0]; end
      3'd1: return a + (~b) + 4'd1;
      3'd2: return 4'(a << b);
      3'd3: return 4'(a >> b);
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return 4'hF - a;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op,
                       input logic [3:0] a,
                       input logic [3:0] b,
                       input logic       ua,
                       input int         bp);
    int   w;
    exp_t e;
    logic [3:0] av;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rdy_wait", {31'd0, cmd_ready}, 32'd1);
    av   = ua ? m_acc : a;
    e.d  = ref_res(op, av, b);
    e.op = op;
    sb.push_back(e);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    rsp_ready   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a     = ~a;
    cmd_b     = ~b;
    chk("alu_a", {28'd0, alu_a}, {28'd0, av});
    chk("alu_b", {28'd0, alu_b}, {28'd0, b});
    chk("alu_x", {29'd0, alu_x}, {29'd0, {3{op[0]}}});
    chk("alu_y", {29'd0, alu_y}, {29'd0, {3{op[1]}}});
    chk("alu_z", {29'd0, alu_z}, {29'd0, {3{op[2]}}});
    chk("exec_vld", {31'd0, rsp_valid}, 32'd0);
    chk("exec_rdy", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = (bp == 0);
    @(negedge clk);
    chk("resp_vld", {31'd0, rsp_valid}, 32'd1);
    e = sb.pop_front();
    chk("rsp_data", {28'd0, rsp_data}, {28'd0, e.d});
    chk("rsp_zero", {31'd0, rsp_zero},
        {31'd0, (e.d == 4'h0)});
    chk("rsp_op", {29'd0, rsp_op}, {29'd0, e.op});
    chk("acc", {28'd0, acc}, {28'd0, e.d});
    m_acc = e.d;
    for (int i = 0; i < bp; i++) begin
      cmd_valid   = 1'b1;
      cmd_op      = ~op;
      cmd_a       = 4'(i + 3);
      cmd_use_acc = 1'b0;
      @(negedge clk);
      chk("bp_vld", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {28'd0, rsp_data}, {28'd0, e.d});
      chk("bp_zero", {31'd0, rsp_zero},
          {31'd0, (e.d == 4'h0)});
      chk("bp_op", {29'd0, rsp_op}, {29'd0, e.op});
      chk("bp_acc", {28'd0, acc}, {28'd0, e.d});
      chk("bp_rdy", {31'd0, cmd_ready}, 32'd0);
      chk("bp_alu_a", {28'd0, alu_a}, {28'd0, av});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    m_cnt = m_cnt + 2'd1;
    chk("done_vld", {31'd0, rsp_valid}, 32'd0);
    chk("done_rdy", {31'd0, cmd_ready}, 32'd1);
    chk("op_count", {30'd0, op_count}, {30'd0, m_cnt});
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_a       = 4'h0;
    cmd_b       = 4'h0;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, cmd_ready}, 32'd0);
    chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_regs",
        {alu_a, alu_b, alu_x, alu_y, alu_z,
         rsp_data, rsp_op, acc, op_count},
        32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", {31'd0, cmd_ready}, 32'd1);

    do_op(3'd0, 4'd9, 4'd8, 1'b0, 0);
    do_op(3'd1, 4'd3, 4'd3, 1'b0, 0);
    do_op(3'd0, 4'd0, 4'd1, 1'b0, 0);
    do_op(3'd2, 4'hF, 4'd2, 1'b1, 0);
    do_op(3'd7, 4'h0, 4'h0, 1'b1, 0);
    chk("chain_acc", {28'd0, acc}, 32'hB);
    do_op(3'd6, 4'hC, 4'h6, 1'b0, 5);

    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = 3'd0;
    cmd_a       = 4'd5;
    cmd_b       = 4'd2;
    cmd_use_acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_exec", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rdy", {31'd0, cmd_ready}, 32'd0);
    chk("mid_vld", {31'd0, rsp_valid}, 32'd0);
    chk("mid_acc", {28'd0, acc}, 32'd0);
    chk("mid_cnt", {30'd0, op_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("mid_novld", {31'd0, rsp_valid}, 32'd0);
    m_acc = 4'h0;
    m_cnt = 2'd0;

    do_op(3'd6, 4'hA, 4'h5, 1'b0, 0);
    do_op(3'd4, 4'h0, 4'h3, 1'b1, 0);
    do_op(3'd3, 4'h8, 4'h3, 1'b0, 0);
    do_op(3'd5, 4'h0, 4'h0, 1'b0, 0);
    chk("wrap_cnt", {30'd0, op_count}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
